gb_cpu_sequencer: RTL

Parametrised M-cycle micro-op sequencer for the SM83 core. It is the successor to the fixed-depth scheduler. It steps through a decoded instruction schedule of up to MAX_STEPS control words and terminates early on a failed condition. It also tracks CB prefixing, owns IME with the EI one-instruction delay, and adds HALT and interrupt-dispatch injection. It sits between the decoder (schedule source) and the datapath (control consumer).

---
 rtl/gb_cpu_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gb_cpu_sequencer.sv
// SM83 M-cycle micro-op sequencer: walks a decoded schedule, handles CB prefix, IME/EI delay,
// HALT and interrupt-dispatch injection. Optional macro GB_CPU_SEQ_HALT_BUG_EN enables the HALT bug.
module gb_cpu_sequencer #(
  parameter int                CTRL_W     = 64,
  parameter int                MAX_STEPS  = 6,
  parameter int                IRQ_STEPS  = 5,
  parameter logic [CTRL_W-1:0] FETCH_CTRL = '0,
  localparam int               CNT_W      = $clog2(MAX_STEPS + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [MAX_STEPS*CTRL_W-1:0]   sched_ctrl,
  input  logic [CNT_W-1:0]              sched_len,
  input  logic                          sched_cb_next,
  input  logic                          sched_ei,
  input  logic                          sched_di,
  input  logic                          sched_halt,
  input  logic [IRQ_STEPS*CTRL_W-1:0]   irq_ctrl,
  input  logic                          cond_not_met,
  input  logic                          irq_pending,
  output logic [CTRL_W-1:0]             control_next,
  output logic [CNT_W-1:0]              step_idx,
  output logic                          cb_prefix_o,
  output logic                          ime,
  output logic                          irq_ack,
  output logic                          halted,
  output logic                          halt_bug,
  output logic [1:0]                    dbg_state
);

  localparam logic [1:0] S_EXEC = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_DISP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic              cb_q, cb_d;
  logic              ime_q, ime_d;
  logic              eid_q, eid_d;
  logic              ack_q, ack_d;
  logic              halted_q, halted_d;
  logic              bug_q, bug_d;

  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  step_inc;
  logic              last_step;
  logic              irq_take;

  always_comb begin
    if (sched_len == '0)                         len_eff = CNT_W'(1);
    else if (sched_len > CNT_W'(MAX_STEPS))      len_eff = CNT_W'(MAX_STEPS);
    else                                         len_eff = sched_len;
  end

  assign step_inc  = step_q + CNT_W'(1);
  assign last_step = (step_q >= len_eff - CNT_W'(1));
  // Never interrupt between 0xCB and its suffix, nor right after a suffix.
  assign irq_take  = ime_q & irq_pending & ~cb_q & ~(sched_cb_next & ~cond_not_met);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    step_d   = step_q;
    cb_d     = cb_q;
    ime_d    = ime_q;
    eid_d    = eid_q;
    ack_d    = 1'b0;
    halted_d = halted_q;
    bug_d    = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (!last_step && !cond_not_met) begin
          step_d = step_inc;
          ctrl_d = sched_ctrl[int'(step_inc)*CTRL_W +: CTRL_W];
        end else begin
          step_d = '0;
          ctrl_d = FETCH_CTRL;
          cb_d   = sched_cb_next & ~cond_not_met;
          if (eid_q) begin
            ime_d = 1'b1;
            eid_d = 1'b0;
          end
          if (sched_ei) eid_d = 1'b1;
          if (sched_di) begin
            ime_d = 1'b0;
            eid_d = 1'b0;
          end
          if (irq_take) begin
            state_d = S_DISP;
            ctrl_d  = irq_ctrl[CTRL_W-1:0];
            ime_d   = 1'b0;
            eid_d   = 1'b0;
            ack_d   = 1'b1;
            cb_d    = 1'b0;
          end else if (sched_halt) begin
`ifdef GB_CPU_SEQ_HALT_BUG_EN
            if (!ime_q && irq_pending) begin
              bug_d = 1'b1;
            end else begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
`else
            state_d  = S_HALT;
            halted_d = 1'b1;
`endif
          end
        end
      end
      S_HALT: begin
        ctrl_d = FETCH_CTRL;
        step_d = '0;
        if (irq_pending) begin
          halted_d = 1'b0;
          state_d  = S_EXEC;
          if (ime_q) begin
            state_d = S_DISP;
            ctrl_d  = irq_ctrl[CTRL_W-1:0];
            ime_d   = 1'b0;
            eid_d   = 1'b0;
            ack_d   = 1'b1;
          end
        end
      end
      S_DISP: begin
        if (step_q < CNT_W'(IRQ_STEPS - 1)) begin
          step_d = step_inc;
          ctrl_d = irq_ctrl[int'(step_inc)*CTRL_W +: CTRL_W];
        end else begin
          state_d = S_EXEC;
          step_d  = '0;
          ctrl_d  = FETCH_CTRL;
        end
      end
      default: begin
        state_d = S_EXEC;
        step_d  = '0;
        ctrl_d  = FETCH_CTRL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_EXEC;
      ctrl_q   <= FETCH_CTRL;
      step_q   <= '0;
      cb_q     <= 1'b0;
      ime_q    <= 1'b0;
      eid_q    <= 1'b0;
      ack_q    <= 1'b0;
      halted_q <= 1'b0;
      bug_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      step_q   <= step_d;
      cb_q     <= cb_d;
      ime_q    <= ime_d;
      eid_q    <= eid_d;
      ack_q    <= ack_d;
      halted_q <= halted_d;
      bug_q    <= bug_d;
    end
  end

  assign control_next = ctrl_q;
  assign step_idx     = step_q;
  assign cb_prefix_o  = cb_q;
  assign ime          = ime_q;
  assign irq_ack      = ack_q;
  assign halted       = halted_q;
  assign halt_bug     = bug_q;
  assign dbg_state    = state_q;

endmodule
